// File: rtl/lint_master_arbiter.sv
// Round-robin arbiter sharing one LINT master port between NB_MASTERS requesters.
// An in-order ID FIFO routes each response back to the requester that issued it.
module lint_master_arbiter #(
  parameter int NB_MASTERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_MASTERS-1:0]            in_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0] in_add_i,
  input  logic [NB_MASTERS-1:0]            in_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] in_wdata_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] in_be_i,
  output logic [NB_MASTERS-1:0]            in_gnt_o,
  output logic [NB_MASTERS-1:0]            in_r_valid_o,
  output logic [DATA_WIDTH-1:0]            in_r_rdata_o,
  output logic                             in_r_opc_o,
  output logic                             out_req_o,
  output logic [ADDR_WIDTH-1:0]            out_add_o,
  output logic                             out_wen_o,
  output logic [DATA_WIDTH-1:0]            out_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          out_be_o,
  input  logic                             out_gnt_i,
  input  logic                             out_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            out_r_rdata_i,
  input  logic                             out_r_opc_i,
  output logic                             err_o
);

  localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  int               sum;

  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // First asserted request at or after rr_ptr, wrapping modulo NB_MASTERS.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      sum = int'(rr_ptr_q) + i;
      if (sum >= NB_MASTERS) sum = sum - NB_MASTERS;
      if (!found && in_req_i[IDX_W'(sum)]) begin
        found  = 1'b1;
        winner = IDX_W'(sum);
      end
    end
  end

  assign out_req_o = (|in_req_i) & ~fifo_full;
  assign push      = out_req_o & out_gnt_i;
  assign pop       = out_r_valid_i & ~fifo_empty;

  // With no request the winner defaults to 0, so requester 0's payload is driven.
  always_comb begin
    out_add_o   = in_add_i[ADDR_WIDTH-1:0];
    out_wen_o   = in_wen_i[0];
    out_wdata_o = in_wdata_i[DATA_WIDTH-1:0];
    out_be_o    = in_be_i[BE_W-1:0];
    in_gnt_o    = '0;
    in_r_valid_o = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (IDX_W'(i) == winner) begin
        out_add_o   = in_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        out_wen_o   = in_wen_i[i];
        out_wdata_o = in_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        out_be_o    = in_be_i[i*BE_W +: BE_W];
        in_gnt_o[i] = push;
      end
      if (IDX_W'(i) == head) in_r_valid_o[i] = pop;
    end
  end

  assign in_r_rdata_o = out_r_rdata_i;
  assign in_r_opc_o   = out_r_opc_i;
  assign err_o        = err_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (out_r_valid_i & fifo_empty);
    if (push) begin
      rr_ptr_d = (winner == IDX_W'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) fifo_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: doc/lint_master_arbiter.md
Name: lint_master_arbiter

Overview:
- Round-robin arbiter that shares one LINT/TCDM master port (req/gnt, r_valid response) between NB_MASTERS requesters, e.g. the JTAG debug LINT master and a second SoC debug/boot master.
- Tracks the requester of each outstanding transaction in an ID FIFO, so each response returns only to the requester that issued it.
- Sits between the requesters and the SoC interconnect master port.

Parameters:
NB_MASTERS, 2, number of requesters (≥2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8)
MAX_OUTSTANDING, 4, ID FIFO depth (≥1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_req_i  in  NB_MASTERS  per-requester request
in_add_i  in  NB_MASTERS*ADDR_WIDTH  per-requester address, packed, requester 0 in LSBs
in_wen_i  in  NB_MASTERS  per-requester write-enable-n (1=read)
in_wdata_i  in  NB_MASTERS*DATA_WIDTH  per-requester write data
in_be_i  in  NB_MASTERS*DATA_WIDTH/8  per-requester byte enables
in_gnt_o  out  NB_MASTERS  per-requester grant
in_r_valid_o  out  NB_MASTERS  per-requester response valid
in_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
in_r_opc_o  out  1  response error, broadcast
out_req_o  out  1  shared-port request
out_add_o  out  ADDR_WIDTH  shared-port address
out_wen_o  out  1  shared-port wen
out_wdata_o  out  DATA_WIDTH  shared-port write data
out_be_o  out  DATA_WIDTH/8  shared-port byte enables
out_gnt_i  in  1  shared-port grant
out_r_valid_i  in  1  shared-port response valid
out_r_rdata_i  in  DATA_WIDTH  shared-port read data
out_r_opc_i  in  1  shared-port response error
err_o  out  1  sticky protocol error: response received with no outstanding transaction

Behaviour:
- Requester protocol: a requester holds req and its payload stable until gnt. Exactly one response (r_valid) follows each granted transaction, in order, at least 1 cycle after gnt.
- Registered state:
  - rr_ptr (clog2 NB_MASTERS bits): highest-priority index.
  - ID FIFO: MAX_OUTSTANDING entries of requester index, with count.
  - err_o.
- Reset (async): rr_ptr=0, FIFO empty, err_o=0. With no in_req_i asserted, out_req_o=0, all in_gnt_o=0 and all in_r_valid_o=0.
- Selection (combinational): winner = first asserted in_req_i at or after rr_ptr, searching upward modulo NB_MASTERS.
- Shared port: out_add/wen/wdata/be_o = winner's payload. When there are no requests, drive requester 0's payload.
- out_req_o = |in_req_i AND fifo_not_full.
- in_gnt_o[winner] = out_gnt_i AND out_req_o. All other grant bits are 0. Grant is zero-latency, same cycle as out_gnt_i.
- Handshake (out_req_o & out_gnt_i) at a clock edge:
  - push winner into the FIFO.
  - rr_ptr <= (winner+1) mod NB_MASTERS, so the last winner gets lowest priority.
- Without a handshake, rr_ptr holds, so the selection is stable while a requester waits for gnt.
- Response: on out_r_valid_i with FIFO non-empty:
  - in_r_valid_o[fifo_head] = 1 in the same cycle; all other bits are 0.
  - pop at the edge.
  - in_r_rdata_o = out_r_rdata_i and in_r_opc_o = out_r_opc_i, passed through combinationally.
- out_r_valid_i with FIFO empty: no in_r_valid_o is asserted, the response is dropped, and err_o is set. err_o is cleared only by reset.
- Simultaneous push and pop in the same cycle: count is unchanged and the head advances. This is legal when the FIFO is full, but out_req_o is already 0 when full. Full backpressures new requests even if a pop occurs in the same cycle; the request is accepted in the following cycle at the earliest.
- Pointers wrap modulo MAX_OUTSTANDING. Count ranges 0..MAX_OUTSTANDING.
- Reset mid-operation: FIFO contents are discarded. Responses arriving after reset for pre-reset transactions set err_o.
- No combinational path from in_req_i to out_gnt_i is assumed. A combinational path out_gnt_i→in_gnt_o exists by design.

Test Plan:
- Single read: only requester 1 requests add=0x1A10_0000, out_gnt_i=1 → in_gnt_o=2'b10 in the same cycle. The following cycle, out_r_valid_i=1 with rdata=0xDEAD_BEEF → in_r_valid_o=2'b10 and in_r_rdata_o=0xDEAD_BEEF. rr_ptr becomes 0.
- Fairness: both requesters request continuously, out_gnt_i=1 every cycle, responses returned 1 cycle later → grants alternate 0,1,0,1. Each response is routed to the matching issuer. Payload on out_add_o matches the granted requester.
- Backpressure: MAX_OUTSTANDING=4, requester 0 holds req, out_gnt_i=1, no responses → 4 grants, then out_req_o=0. One out_r_valid_i pops → out_req_o=1 in the next cycle and a 5th grant is issued.
- Delayed grant: requester 0 requests with out_gnt_i=0 for 3 cycles while requester 1 also requests → winner and out_add_o stay at requester 0 for all 3 cycles. On gnt, rr_ptr=1 and requester 1 is granted next.
- Spurious response: out_r_valid_i=1 with FIFO empty → all in_r_valid_o=0 and err_o=1, persisting until rst_ni=0.
- Reset mid-flight: 2 outstanding transactions, assert rst_ni=0 asynchronously → out_req_o/in_gnt_o drop immediately, FIFO empty, rr_ptr=0. A later response sets err_o.
